// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - Scancode/ASCII constants and modifier state shared by the keyboard queue.
package kbd_pkg;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_ESC    = 8'h76;
    localparam logic [7:0] SC_TAB    = 8'h0D;

    localparam logic [7:0] ASC_NUL = 8'h00;
    localparam logic [7:0] ASC_BS  = 8'h08;
    localparam logic [7:0] ASC_TAB = 8'h09;
    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_ESC = 8'h1B;
    localparam logic [7:0] ASC_SP  = 8'h20;

    typedef struct packed {
        logic shift_l;
        logic shift_r;
        logic ctrl;
        logic caps;
    } mod_state_t;

    function automatic logic is_modifier(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT) ||
               (code == SC_CTRL)   || (code == SC_CAPS);
    endfunction

endpackage

// File: rtl/scancode_to_ascii.sv
// rtl/scancode_to_ascii.sv - Combinational PS/2 set-2 scancode to ASCII translation.
module scancode_to_ascii
    import kbd_pkg::*;
(
    input  logic [7:0] keyCode,
    input  mod_state_t mods,
    output logic [7:0] ascii,
    output logic       valid
);

    logic [7:0] base;
    logic [7:0] shifted;
    logic       is_letter;
    logic       shift;

    assign shift = mods.shift_l | mods.shift_r;

    always_comb begin
        base      = ASC_NUL;
        shifted   = ASC_NUL;
        is_letter = 1'b0;
        case (keyCode)
            8'h1C: begin base = "a"; is_letter = 1'b1; end
            8'h32: begin base = "b"; is_letter = 1'b1; end
            8'h21: begin base = "c"; is_letter = 1'b1; end
            8'h23: begin base = "d"; is_letter = 1'b1; end
            8'h24: begin base = "e"; is_letter = 1'b1; end
            8'h2B: begin base = "f"; is_letter = 1'b1; end
            8'h34: begin base = "g"; is_letter = 1'b1; end
            8'h33: begin base = "h"; is_letter = 1'b1; end
            8'h43: begin base = "i"; is_letter = 1'b1; end
            8'h3B: begin base = "j"; is_letter = 1'b1; end
            8'h42: begin base = "k"; is_letter = 1'b1; end
            8'h4B: begin base = "l"; is_letter = 1'b1; end
            8'h3A: begin base = "m"; is_letter = 1'b1; end
            8'h31: begin base = "n"; is_letter = 1'b1; end
            8'h44: begin base = "o"; is_letter = 1'b1; end
            8'h4D: begin base = "p"; is_letter = 1'b1; end
            8'h15: begin base = "q"; is_letter = 1'b1; end
            8'h2D: begin base = "r"; is_letter = 1'b1; end
            8'h1B: begin base = "s"; is_letter = 1'b1; end
            8'h2C: begin base = "t"; is_letter = 1'b1; end
            8'h3C: begin base = "u"; is_letter = 1'b1; end
            8'h2A: begin base = "v"; is_letter = 1'b1; end
            8'h1D: begin base = "w"; is_letter = 1'b1; end
            8'h22: begin base = "x"; is_letter = 1'b1; end
            8'h35: begin base = "y"; is_letter = 1'b1; end
            8'h1A: begin base = "z"; is_letter = 1'b1; end
            8'h16: {base, shifted} = {"1", "!"};
            8'h1E: {base, shifted} = {"2", "@"};
            8'h26: {base, shifted} = {"3", "#"};
            8'h25: {base, shifted} = {"4", "$"};
            8'h2E: {base, shifted} = {"5", "%"};
            8'h36: {base, shifted} = {"6", "^"};
            8'h3D: {base, shifted} = {"7", "&"};
            8'h3E: {base, shifted} = {"8", "*"};
            8'h46: {base, shifted} = {"9", "("};
            8'h45: {base, shifted} = {"0", ")"};
            8'h0E: {base, shifted} = {8'h60, "~"};
            8'h4E: {base, shifted} = {"-", "_"};
            8'h55: {base, shifted} = {"=", "+"};
            8'h54: {base, shifted} = {"[", "{"};
            8'h5B: {base, shifted} = {"]", "}"};
            8'h5D: {base, shifted} = {"\\", "|"};
            8'h4C: {base, shifted} = {";", ":"};
            8'h52: {base, shifted} = {"'", "\""};
            8'h41: {base, shifted} = {",", "<"};
            8'h49: {base, shifted} = {".", ">"};
            8'h4A: {base, shifted} = {"/", "?"};
            SC_ENTER: {base, shifted} = {ASC_CR,  ASC_CR};
            SC_BKSP:  {base, shifted} = {ASC_BS,  ASC_BS};
            SC_SPACE: {base, shifted} = {ASC_SP,  ASC_SP};
            SC_ESC:   {base, shifted} = {ASC_ESC, ASC_ESC};
            SC_TAB:   {base, shifted} = {ASC_TAB, ASC_TAB};
            default: begin
                base    = ASC_NUL;
                shifted = ASC_NUL;
            end
        endcase
    end

    // Letters honour caps lock and ctrl; everything else only cares about shift.
    always_comb begin
        ascii = ASC_NUL;
        if (is_letter) begin
            if (mods.ctrl)
                ascii = base & 8'h1F;
            else if (shift ^ mods.caps)
                ascii = base & 8'hDF;
            else
                ascii = base;
        end else begin
            ascii = shift ? shifted : base;
        end
    end

    assign valid = (ascii != ASC_NUL);

endmodule

// File: rtl/kbd_ascii_queue.sv
// rtl/kbd_ascii_queue.sv - Key events to ASCII FIFO with KBSR/KBDR view; KBD_IRQ_EN adds interrupt enable and irq.
module kbd_ascii_queue
    import kbd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [7:0]       keyCode,
    input  logic             press,
    input  logic             kbdr_rd,
    input  logic             overflow_clr,
    output logic             kbsr_ready,
    output logic [7:0]       kbdr_data,
    output logic [CNT_W-1:0] count,
    output logic             overflow
`ifdef KBD_IRQ_EN
    ,
    input  logic             kbsr_ie_wr,
    input  logic             kbsr_ie_din,
    output logic             kbsr_ie,
    output logic             irq
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [8:0]       prev_q;
    logic             key_event;
    mod_state_t       mods_q, mods_d;
    logic [7:0]       tr_ascii;
    logic             tr_valid;
    logic             enq;
    logic [7:0]       s1_char_q;
    logic             s1_valid_q;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, pop, push_ok, push_drop;

    assign key_event = ({press, keyCode} != prev_q);

    scancode_to_ascii u_xlate (
        .keyCode (keyCode),
        .mods    (mods_q),
        .ascii   (tr_ascii),
        .valid   (tr_valid)
    );

    assign enq = key_event & press & tr_valid & ~is_modifier(keyCode);

    always_comb begin
        mods_d = mods_q;
        if (key_event) begin
            case (keyCode)
                SC_LSHIFT: mods_d.shift_l = press;
                SC_RSHIFT: mods_d.shift_r = press;
                SC_CTRL:   mods_d.ctrl    = press;
                SC_CAPS:   if (press) mods_d.caps = ~mods_q.caps;
                default:   mods_d = mods_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            prev_q     <= 9'd0;
            mods_q     <= '0;
            s1_char_q  <= 8'h00;
            s1_valid_q <= 1'b0;
        end else begin
            prev_q     <= {press, keyCode};
            mods_q     <= mods_d;
            s1_char_q  <= tr_ascii;
            s1_valid_q <= enq;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop       = kbdr_rd & ~empty;
    assign push_ok   = s1_valid_q & (~full | pop);
    assign push_drop = s1_valid_q & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (push_ok & ~pop)
            count_d = count_q + CNT_W'(1);
        else if (pop & ~push_ok)
            count_d = count_q - CNT_W'(1);
        ovf_d = push_drop | (ovf_q & ~overflow_clr);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= s1_char_q;
    end

    assign kbsr_ready = ~empty;
    assign kbdr_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count      = count_q;
    assign overflow   = ovf_q;

`ifdef KBD_IRQ_EN
    logic ie_q, irq_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (kbsr_ie_wr) ie_q <= kbsr_ie_din;
            irq_q <= ~empty & ie_q;
        end
    end

    assign kbsr_ie = ie_q;
    assign irq     = irq_q;
`endif

endmodule

// File: tb/tb_kbd_ascii_queue.sv
// tb/tb_kbd_ascii_queue.sv - Scoreboard bench for kbd_ascii_queue (covers KBD_IRQ_EN when defined).
module tb_kbd_ascii_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic [7:0]       keyCode = 8'h00;
    logic             press = 1'b0;
    logic             kbdr_rd = 1'b0;
    logic             overflow_clr = 1'b0;
    logic             kbsr_ready;
    logic [7:0]       kbdr_data;
    logic [CNT_W-1:0] count;
    logic             overflow;
`ifdef KBD_IRQ_EN
    logic kbsr_ie_wr = 1'b0;
    logic kbsr_ie_din = 1'b0;
    logic kbsr_ie;
    logic irq;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] sb[$];

    kbd_ascii_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .keyCode      (keyCode),
        .press        (press),
        .kbdr_rd      (kbdr_rd),
        .overflow_clr (overflow_clr),
        .kbsr_ready   (kbsr_ready),
        .kbdr_data    (kbdr_data),
        .count        (count),
        .overflow     (overflow)
`ifdef KBD_IRQ_EN
        ,
        .kbsr_ie_wr   (kbsr_ie_wr),
        .kbsr_ie_din  (kbsr_ie_din),
        .kbsr_ie      (kbsr_ie),
        .irq          (irq)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic ev(input logic [7:0] code, input logic pr);
        keyCode = code;
        press   = pr;
        tick(1);
    endtask

    task automatic make(input logic [7:0] code, input logic [7:0] exp);
        ev(code, 1'b1);
        if (exp != 8'h00) sb.push_back(exp);
        tick(2);
    endtask

    task automatic brk(input logic [7:0] code);
        ev(code, 1'b0);
        tick(2);
    endtask

    task automatic pop_chk(input string tag);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_ready"}, 32'(kbsr_ready), 32'd1);
            chk({tag, "_data"}, 32'(kbdr_data), 32'(exp));
        end
        kbdr_rd = 1'b1;
        tick(1);
        kbdr_rd = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1 && sb.size() != 0; i++) pop_chk(tag);
        chk({tag, "_empty_ready"}, 32'(kbsr_ready), 32'd0);
        chk({tag, "_empty_count"}, 32'(count), 32'd0);
    endtask

    localparam logic [7:0] OVF_CODES [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};

    initial begin
        tick(3);
        chk("rst_ready", 32'(kbsr_ready), 32'd0);
        chk("rst_data", 32'(kbdr_data), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        Reset = 1'b1;
        tick(3);
        chk("idle_no_event", 32'(count), 32'd0);

        make(8'h1C, 8'h61);
        brk(8'h1C);
        chk("basic_count", 32'(count), 32'd1);
        pop_chk("basic");
        chk("basic_after_ready", 32'(kbsr_ready), 32'd0);
        chk("basic_after_data", 32'(kbdr_data), 32'h00);

        make(8'h12, 8'h00);
        make(8'h16, 8'h21);
        brk(8'h12);
        make(8'h58, 8'h00);
        make(8'h1C, 8'h41);
        make(8'h12, 8'h00);
        make(8'h1C, 8'h61);
        brk(8'h12);
        make(8'h58, 8'h00);
        brk(8'h58);
        chk("shift_count", 32'(count), 32'd3);
        drain("shift");

        make(8'h14, 8'h00);
        make(8'h21, 8'h03);
        brk(8'h14);
        make(8'h5A, 8'h0D);
        make(8'h29, 8'h20);
        drain("ctrl");

        kbdr_rd = 1'b1;
        tick(1);
        kbdr_rd = 1'b0;
        chk("rd_empty_count", 32'(count), 32'd0);
        chk("rd_empty_data", 32'(kbdr_data), 32'h00);

        for (int i = 0; i < 9; i++)
            make(OVF_CODES[i], (i < DEPTH) ? 8'(8'h61 + i) : 8'h00);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_head", 32'(kbdr_data), 32'(sb[0]));
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        ev(8'h3B, 1'b1);
        chk("full_pop_data", 32'(kbdr_data), 32'(sb.pop_front()));
        sb.push_back(8'h6A);
        kbdr_rd = 1'b1;
        tick(1);
        kbdr_rd = 1'b0;
        tick(1);
        chk("full_pop_count", 32'(count), 32'(DEPTH));
        chk("full_pop_ovf", 32'(overflow), 32'd0);

        ev(8'h42, 1'b1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        overflow_clr = 1'b1;
        tick(1);
        overflow_clr = 1'b0;
        drain("ovf");

        ev(8'h4B, 1'b1);
        Reset   = 1'b0;
        keyCode = 8'h00;
        press   = 1'b0;
        tick(2);
        chk("midrst_ready", 32'(kbsr_ready), 32'd0);
        Reset = 1'b1;
        tick(3);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_ready2", 32'(kbsr_ready), 32'd0);

`ifdef KBD_IRQ_EN
        chk("ie_rst", 32'(kbsr_ie), 32'd0);
        kbsr_ie_wr  = 1'b1;
        kbsr_ie_din = 1'b1;
        tick(1);
        kbsr_ie_wr  = 1'b0;
        chk("ie_set", 32'(kbsr_ie), 32'd1);
        ev(8'h1C, 1'b1);
        sb.push_back(8'h61);
        tick(1);
        chk("irq_ready", 32'(kbsr_ready), 32'd1);
        chk("irq_lag", 32'(irq), 32'd0);
        tick(1);
        chk("irq_high", 32'(irq), 32'd1);
        pop_chk("irq");
        chk("irq_hold", 32'(irq), 32'd1);
        tick(1);
        chk("irq_drop", 32'(irq), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/kbd_ascii_queue.md
Name: kbd_ascii_queue

Overview:
Sits directly downstream of the PS/2 keyboard driver and consumes its level outputs `keyCode[7:0]` and `press`. It turns each key event into ASCII and tracks modifier state (shift, ctrl, caps lock). Printable and control characters are buffered in a small FIFO. The FIFO is exposed to the LC-3 memory-mapped I/O logic as a KBSR ready bit plus KBDR data, and a KBDR read pops one character.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- Clk, input, 1, system clock.
- Reset, input, 1, asynchronous active-low reset.
- keyCode, input, 8, scancode from the keyboard driver, synchronous to Clk.
- press, input, 1, 1 = make, 0 = break; held until the next event.
- kbdr_rd, input, 1, one-cycle pulse on a KBDR read; pops the FIFO head.
- overflow_clr, input, 1, clears the sticky overflow flag.
- kbsr_ready, output, 1, FIFO not empty (KBSR[15]).
- kbdr_data, output, 8, FIFO head; 0x00 when empty.
- count, output, CNT_W, FIFO occupancy.
- overflow, output, 1, sticky: a character was dropped because the FIFO was full.

Behaviour:
- **Reset (Reset=0, async):**
  - FIFO empty; kbsr_ready=0, kbdr_data=0x00, count=0, overflow=0.
  - Modifiers cleared.
  - Previous-input register loaded with {press=0, keyCode=0x00}, so no spurious event on release of reset.
- **Event detect:** every cycle register {press, keyCode}. An event is a cycle where the current value differs from the registered value. Exactly one event per change.
- **Modifier update (on event):**
  - 0x12 (LShift) and 0x59 (RShift) set or clear their own bit from `press`; shift = LShift | RShift.
  - 0x14 (ctrl) follows `press`.
  - 0x58 (caps lock) toggles on make only.
  - Modifier keys never enqueue a character.
- **Translation (on make events only):** performed by a combinational sub-module.
  - Letters 0x1C..: lowercase; uppercase if shift XOR caps.
  - Digits and punctuation: shifted table when shift=1; caps has no effect.
  - 0x5A gives 0x0D; 0x66 gives 0x08; 0x29 gives 0x20; 0x76 gives 0x1B; 0x0D gives 0x09.
  - Ctrl held with a letter gives (uppercase ASCII & 0x1F).
  - Unmapped codes give 0x00 and are not enqueued.
  - Break events never enqueue.
- **Pipeline:**
  - Stage 1 registers {char, valid} on the edge after the event.
  - Stage 2 writes the FIFO on the following edge.
  - kbsr_ready rises 2 Clk edges after the input change is sampled.
- **FIFO:**
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits, wrapping at DEPTH.
  - kbdr_data is combinational from the head entry.
- **kbdr_rd when empty:** ignored; no pointer change.
- **Push when full:**
  - Character dropped and overflow set.
  - If kbdr_rd is high in the same cycle, the pop happens first and the push succeeds; overflow is not set.
- **Push and pop on a non-empty, non-full FIFO in the same cycle:** count unchanged.
- **overflow_clr and a new overflow in the same cycle:** overflow stays set (set wins).
- **Reset asserted mid-pipeline:** the in-flight character is discarded.

Optional Feature:
- **Macro:** KBD_IRQ_EN.
- **When defined, added ports:**
  - kbsr_ie_wr, input, 1: write strobe.
  - kbsr_ie_din, input, 1: value to write.
  - kbsr_ie, output, 1: KBSR[14] interrupt enable; reset 0.
  - irq, output, 1: registered, equal to kbsr_ready & kbsr_ie; one cycle behind kbsr_ready.
- **When undefined:** these ports do not exist and there is no interrupt logic.

Decomposition:
- **Shared package kbd_pkg:**
  - Scancode constants: SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CTRL=8'h14, SC_CAPS=8'h58, SC_ENTER=8'h5A, SC_BKSP=8'h66.
  - ASCII constants.
  - Struct mod_state_t {shift_l, shift_r, ctrl, caps}.
- **Sub-module scancode_to_ascii:** combinational; inputs keyCode and mod_state_t; outputs {ascii[7:0], valid}.

Test Plan:
- **Basic letter:** make 0x1C, then break 0x1C → one entry, kbdr_data=0x61, count=1. Pulse kbdr_rd → kbsr_ready=0, kbdr_data=0x00.
- **Shift and caps:**
  - Make 0x12, make 0x16 → enqueue 0x21 ('!').
  - Break 0x12, make 0x58, make 0x1C → enqueue 0x41.
  - With caps on and shift held, make 0x1C → 0x61.
- **Ctrl:** ctrl held, make 0x21 ('c') → enqueue 0x03. Make 0x5A → 0x0D.
- **Overflow:**
  - DEPTH=8; 9 distinct makes without reads → count=8, overflow=1, head still the first character.
  - overflow_clr → overflow=0.
  - Full FIFO, a push coincident with kbdr_rd → count stays 8, overflow stays 0.
- **Reset behaviour:**
  - Async Reset low one cycle after an event → no entry appears, kbsr_ready=0.
  - Holding keyCode=0x00, press=0 after reset → no event.
- **KBD_IRQ_EN:** write ie=1, make 0x1C → irq asserts one cycle after kbsr_ready. Pop → irq drops the next cycle.
